// File: rtl/dmem_arb_if.sv
// Bus bundle between the stack core, the host burst loader and the data memory.
// The arbiter takes the slave view; the environment around it takes the master view.
interface dmem_arb_if #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
);
  logic          core_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata;
  logic [DW-1:0] core_rdata;
  logic          core_stall;

  logic          host_start;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic [LW-1:0] host_len;
  logic [DW-1:0] host_wdata;
  logic          host_wvalid;
  logic [DW-1:0] host_rdata;
  logic          host_rvalid;
  logic          host_busy;
  logic          host_done;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  host_start, host_wr, host_addr, host_len, host_wdata, host_wvalid,
    output host_rdata, host_rvalid, host_busy, host_done,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output host_start, host_wr, host_addr, host_len, host_wdata, host_wvalid,
    input  host_rdata, host_rvalid, host_busy, host_done,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb.sv
// Shares the single-port data memory between the stack core (default owner) and
// a host burst loader; a granted burst runs to completion while the core stalls.
module dmem_arb #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 8
) (
  input  logic        clk,
  input  logic        reset,
  dmem_arb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PEND, BURST, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          beat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    wr_d           = wr_q;
    rdata_d        = rdata_q;
    rvalid_d       = 1'b0;
    beat           = 1'b0;
    bus.mem_we     = bus.core_req & bus.core_we;
    bus.mem_addr   = bus.core_addr;
    bus.mem_wdata  = bus.core_wdata;
    bus.core_rdata = bus.mem_rdata;
    bus.core_stall = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.host_start) begin
          addr_d  = bus.host_addr;
          cnt_d   = bus.host_len;
          wr_d    = bus.host_wr;
          state_d = (bus.host_len == '0) ? DONE : PEND;
        end
      end
      // Wait for a cycle the core leaves the port alone; that cycle carries no beat.
      PEND: begin
        if (!bus.core_req) state_d = BURST;
      end
      BURST: begin
        bus.core_rdata = '0;
        bus.core_stall = bus.core_req;
        bus.mem_addr   = addr_q;
        bus.mem_wdata  = bus.host_wdata;
        bus.mem_we     = wr_q & bus.host_wvalid;
        beat           = ~wr_q | bus.host_wvalid;
        if (beat) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - LW'(1);
          if (!wr_q) begin
            rdata_d  = bus.mem_rdata;
            rvalid_d = 1'b1;
          end
          if (cnt_q == LW'(1)) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.host_rdata  = rdata_q;
  assign bus.host_rvalid = rvalid_q;
  assign bus.host_done   = (state_q == DONE);
  assign bus.host_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arb.sv
// Randomized scoreboard bench for dmem_arb: stimulus predicts memory writes, read
// beats, done pulses, core responses and busy levels; a negedge monitor checks them.
module tb_dmem_arb;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arb_if #(.AW(AW), .DW(DW), .LW(LW)) bus();
  dmem_arb #(.AW(AW), .DW(DW), .LW(LW)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [DW-1:0] mem [256];
  int            init_val [256];
  int            ref_mem [256];
  logic          preload;

  assign bus.mem_rdata = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(init_val[i]);
    end else if (bus.mem_we === 1'b1) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int a; int d; int c;} wr_t;
  typedef struct {int d; int c;} rd_t;
  typedef struct {bit stall; bit rd; int d;} core_t;
  typedef struct {int c; bit v;} busy_t;

  wr_t   exp_wr[$];
  rd_t   exp_rd[$];
  int    exp_done[$];
  core_t exp_core[$];
  busy_t exp_busy[$];

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: consumes expectations whenever the DUT shows an event.
  always @(negedge clk) begin : mon
    wr_t   w;
    rd_t   r;
    core_t e;
    busy_t b;
    int    dn;
    if (mon_en && reset === 1'b0) begin
      if (bus.mem_we !== 1'b0) begin
        if (exp_wr.size() == 0) check("spurious_mem_we", 32'(bus.mem_we), 32'(0));
        else begin
          w = exp_wr.pop_front();
          check("wr_addr", 32'(bus.mem_addr), w.a);
          check("wr_data", 32'(bus.mem_wdata), w.d);
          check("wr_cycle", cyc, w.c);
        end
      end
      if (bus.host_rvalid !== 1'b0) begin
        if (exp_rd.size() == 0) check("spurious_rvalid", 32'(bus.host_rvalid), 32'(0));
        else begin
          r = exp_rd.pop_front();
          check("rd_data", 32'(bus.host_rdata), r.d);
          check("rd_cycle", cyc, r.c);
        end
      end
      if (bus.host_done !== 1'b0) begin
        if (exp_done.size() == 0) check("spurious_done", 32'(bus.host_done), 32'(0));
        else begin
          dn = exp_done.pop_front();
          check("done_cycle", cyc, dn);
        end
      end
      if (bus.core_req === 1'b1 && exp_core.size() > 0) begin
        e = exp_core.pop_front();
        check("core_stall", 32'(bus.core_stall), 32'(e.stall));
        if (e.rd || e.stall) check("core_rdata", 32'(bus.core_rdata), e.d);
      end else if (bus.core_req === 1'b0) begin
        check("stall_no_req", 32'(bus.core_stall), 32'(0));
      end
      while (exp_busy.size() > 0 && exp_busy[0].c <= cyc) begin
        b = exp_busy.pop_front();
        check("host_busy", 32'(bus.host_busy), 32'(b.v));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.core_req    = 1'b0;
    bus.core_we     = 1'b0;
    bus.core_addr   = '0;
    bus.core_wdata  = '0;
    bus.host_start  = 1'b0;
    bus.host_wr     = 1'b0;
    bus.host_addr   = '0;
    bus.host_len    = '0;
    bus.host_wdata  = '0;
    bus.host_wvalid = 1'b0;
  endtask

  task automatic push_busy(bit v);
    busy_t b;
    b.c = cyc;
    b.v = v;
    exp_busy.push_back(b);
  endtask

  // Core access in a cycle where the core owns the port.
  task automatic core_op(bit we, int a, int d);
    core_t e;
    wr_t   w;
    bus.core_req   = 1'b1;
    bus.core_we    = we;
    bus.core_addr  = 8'(a);
    bus.core_wdata = 8'(d);
    e.stall = 1'b0;
    e.rd    = !we;
    e.d     = ref_mem[a & 255];
    exp_core.push_back(e);
    if (we) begin
      w.a = a & 255;
      w.d = d & 255;
      w.c = cyc;
      exp_wr.push_back(w);
      ref_mem[a & 255] = d & 255;
    end
  endtask

  task automatic rand_core_op();
    core_op(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
  endtask

  task automatic noise_start();
    bus.host_start = 1'b1;
    bus.host_wr    = 1'($urandom_range(0, 1));
    bus.host_addr  = 8'($urandom_range(0, 255));
    bus.host_len   = 8'($urandom_range(0, 3));
  endtask

  // core_mode: 0 core idle in burst, 1 core writes every burst cycle, 2 random.
  task automatic burst(bit wr, int addr, int len, int pend_n, int core_mode,
                       bit noisy, int gap_after, int abort_after);
    int    a;
    int    k;
    int    d;
    bit    v;
    bit    gapped;
    wr_t   w;
    rd_t   r;
    core_t e;
    clear_in();
    bus.host_start = 1'b1;
    bus.host_wr    = wr;
    bus.host_addr  = 8'(addr);
    bus.host_len   = 8'(len);
    push_busy(1'b0);
    if (noisy && $urandom_range(0, 1) == 1) rand_core_op();
    tick();
    clear_in();
    if (len == 0) begin
      exp_done.push_back(cyc);
      push_busy(1'b1);
      if (noisy) noise_start();
      tick();
      clear_in();
      push_busy(1'b0);
      return;
    end
    push_busy(1'b1);
    for (int i = 0; i < pend_n; i++) begin
      rand_core_op();
      if (noisy && i == 0) noise_start();
      tick();
      clear_in();
      push_busy(1'b1);
    end
    tick();
    a = addr & 255;
    k = 0;
    gapped = 1'b0;
    while (k < len) begin
      if (k == abort_after) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_in();
        push_busy(1'b0);
        check("abort_rvalid", 32'(bus.host_rvalid), 32'(0));
        check("abort_rdata", 32'(bus.host_rdata), 32'(0));
        return;
      end
      push_busy(1'b1);
      if (core_mode == 1 || (core_mode == 2 && $urandom_range(0, 2) == 0)) begin
        bus.core_req   = 1'b1;
        bus.core_we    = (core_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        bus.core_addr  = 8'($urandom_range(0, 255));
        bus.core_wdata = 8'($urandom_range(0, 255));
        e.stall = 1'b1;
        e.rd    = 1'b0;
        e.d     = 0;
        exp_core.push_back(e);
      end
      if (noisy && $urandom_range(0, 4) == 0) noise_start();
      if (wr) begin
        v = 1'b1;
        if (k == gap_after && !gapped) begin
          v = 1'b0;
          gapped = 1'b1;
        end else if (noisy && $urandom_range(0, 3) == 0) v = 1'b0;
        d = noisy ? int'($urandom_range(0, 255)) : k + 1;
        bus.host_wvalid = v;
        bus.host_wdata  = 8'(d);
        if (v) begin
          w.a = a;
          w.d = d;
          w.c = cyc;
          exp_wr.push_back(w);
          ref_mem[a] = d;
          a = (a + 1) % 256;
          k++;
        end
      end else begin
        r.d = ref_mem[a];
        r.c = cyc + 1;
        exp_rd.push_back(r);
        a = (a + 1) % 256;
        k++;
      end
      tick();
      clear_in();
    end
    exp_done.push_back(cyc);
    push_busy(1'b1);
    if (noisy) begin
      if ($urandom_range(0, 1) == 1) rand_core_op();
      if ($urandom_range(0, 1) == 1) noise_start();
    end
    tick();
    clear_in();
    push_busy(1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      init_val[i] = int'($urandom_range(0, 255));
      ref_mem[i]  = init_val[i];
    end
    preload = 1'b1;
    reset   = 1'b1;
    clear_in();
    tick();
    tick();
    preload = 1'b0;
    reset   = 1'b0;
    check("rst_busy", 32'(bus.host_busy), 32'(0));
    check("rst_rvalid", 32'(bus.host_rvalid), 32'(0));
    check("rst_done", 32'(bus.host_done), 32'(0));
    check("rst_rdata", 32'(bus.host_rdata), 32'(0));
    check("rst_stall", 32'(bus.core_stall), 32'(0));
    mon_en = 1'b1;

    // Core-only write then read back.
    core_op(1'b1, 'h10, 'h5A);
    tick();
    core_op(1'b0, 'h10, 0);
    tick();
    clear_in();
    tick();

    // Write burst with one wvalid gap after beat 2.
    burst(1'b1, 'h20, 4, 0, 0, 1'b0, 2, -1);
    // Read burst wrapping past the top of memory.
    burst(1'b0, 'hFE, 3, 0, 0, 1'b0, -1, -1);
    // Core busy for 3 cycles at grant, then core writes throughout the burst.
    burst(1'b1, 'h40, 3, 3, 1, 1'b0, -1, -1);
    // Zero-length burst with host_start re-pulsed while busy.
    burst(1'b0, 'h55, 0, 0, 0, 1'b1, -1, -1);
    tick();
    // Reset after 2 of 5 write beats.
    burst(1'b1, 'h30, 5, 0, 0, 1'b0, -1, 2);
    tick();
    tick();

    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 9) < 3) begin
        for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
          rand_core_op();
          tick();
          clear_in();
        end
      end else begin
        burst(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
              ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 8)),
              int'($urandom_range(0, 3)), 2, 1'b1, -1, -1);
      end
    end

    repeat (4) tick();
    check("left_wr", exp_wr.size(), 0);
    check("left_rd", exp_rd.size(), 0);
    check("left_done", exp_done.size(), 0);
    check("left_core", exp_core.size(), 0);
    for (int i = 0; i < 256; i++) check("mem_final", 32'(mem[i]), ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
